// File: rtl/bin_to_rns_9_8_7_if.sv
// bin_to_rns_9_8_7_if: valid/ready bundle between a binary producer and the 9-8-7 RNS forward converter.
interface bin_to_rns_9_8_7_if #(parameter int N_BITS = 9);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        r7;
    logic [2:0]        r8;
    logic [3:0]        r9;
    logic              range_err;
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, r7, r8, r9, range_err);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, r7, r8, r9, range_err);
endinterface

// File: rtl/bin_to_rns_9_8_7.sv
// bin_to_rns_9_8_7: bit-serial MSB-first Horner reduction of a binary value into (mod 7, mod 8, mod 9) residues.
module bin_to_rns_9_8_7 #(parameter int N_BITS = 9) (
    input logic              clk,
    input logic              rst_n,
    bin_to_rns_9_8_7_if.slave bus
);
    localparam int CW = $clog2(N_BITS + 1);
    localparam int EW = N_BITS > 10 ? N_BITS : 10;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t            state;
    logic [N_BITS-1:0] sh;
    logic [CW-1:0]     cnt;
    logic [2:0]        a7, a8;
    logic [3:0]        a9;
    logic              err;
    logic              b;
    logic [3:0]        t7, t8;
    logic [4:0]        t9;
    logic [2:0]        n7, n8;
    logic [3:0]        n9;
    logic [EW-1:0]     ext;
    assign b   = sh[N_BITS-1];
    assign t7  = {a7, b};
    assign t8  = {a8, b};
    assign t9  = {a9, b};
    // t < 2m always, so one conditional subtract completes the reduction; mod 8 is just the low bits
    assign n7  = t7 >= 4'd7 ? 3'(t7 - 4'd7) : t7[2:0];
    assign n8  = t8[2:0];
    assign n9  = t9 >= 5'd9 ? 4'(t9 - 5'd9) : t9[3:0];
    assign ext = EW'(bus.in_data);
    assign bus.in_ready = state == IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sh            <= '0;
            cnt           <= '0;
            a7            <= '0;
            a8            <= '0;
            a9            <= '0;
            err           <= 1'b0;
            bus.r7        <= '0;
            bus.r8        <= '0;
            bus.r9        <= '0;
            bus.range_err <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sh    <= bus.in_data;
                    a7    <= '0;
                    a8    <= '0;
                    a9    <= '0;
                    cnt   <= '0;
                    err   <= ext >= EW'(504);
                    state <= CONV;
                end
                CONV: begin
                    sh  <= sh << 1;
                    a7  <= n7;
                    a8  <= n8;
                    a9  <= n9;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N_BITS - 1)) begin
                        bus.r7        <= n7;
                        bus.r8        <= n8;
                        bus.r9        <= n9;
                        bus.range_err <= err;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_rns_9_8_7.sv
// tb_bin_to_rns_9_8_7: directed literal cases plus randomized sweep checked against an arithmetic residue model.
module tb_bin_to_rns_9_8_7;
    localparam int N = 9;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    bin_to_rns_9_8_7_if #(.N_BITS(N)) bus();
    bin_to_rns_9_8_7 #(.N_BITS(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    // Reference: a transaction is in flight from accept until its output handshake;
    // residues appear N edges after accept and are held until the next completion.
    bit busy, done, acc_pend, hs_pend;
    int k, cur, acc_val, accepts, hs;
    int l7, l8, l9, le;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            if (busy) accepts--;
            busy = 0; done = 0; acc_pend = 0; hs_pend = 0;
            l7 = 0; l8 = 0; l9 = 0; le = 0;
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_in_ready", int'(bus.in_ready), 1);
            chk("rst_res", int'({bus.r7, bus.r8, bus.r9, bus.range_err}), 0);
        end else begin
            if (acc_pend) begin
                busy = 1; k = 0; cur = acc_val; accepts++;
            end else if (busy && !done) begin
                k++;
                if (k == N) begin
                    done = 1;
                    l7 = cur % 7; l8 = cur % 8; l9 = cur % 9; le = int'(cur >= 504);
                end
            end else if (hs_pend) begin
                done = 0; busy = 0; hs++;
            end
            chk("m_out_valid", int'(bus.out_valid), int'(done));
            chk("m_in_ready", int'(bus.in_ready), int'(!busy));
            chk("m_r7", int'(bus.r7), l7);
            chk("m_r8", int'(bus.r8), l8);
            chk("m_r9", int'(bus.r9), l9);
            chk("m_range_err", int'(bus.range_err), le);
            acc_pend = bus.in_valid && !busy;
            acc_val  = int'(bus.in_data);
            hs_pend  = done && bus.out_ready;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 100) begin cycle(); n++; end
        if (n >= 100) chk(name, 0, 1);
    endtask

    task automatic pulse(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = 9'(v);
        cycle();
        bus.in_valid = 1'b0;
        bus.in_data  = 9'($urandom);
    endtask

    task automatic convert(input int v, input int e7, input int e8, input int e9, input int ee, input int stall);
        int n = 0;
        wait_ready("conv_ready_timeout");
        pulse(v);
        while (!bus.out_valid && n < 50) begin cycle(); n++; end
        chk("latency", n, 9);
        chk("lit_r7", int'(bus.r7), e7);
        chk("lit_r8", int'(bus.r8), e8);
        chk("lit_r9", int'(bus.r9), e9);
        chk("lit_range_err", int'(bus.range_err), ee);
        repeat (stall) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 9'd42;
            cycle();
            chk("bp_out_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_hold", int'({bus.r7, bus.r8, bus.r9}), (e7 << 7) | (e8 << 4) | e9);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        bus.out_ready = 1'b0;
        chk("hs_out_valid", int'(bus.out_valid), 0);
        chk("hs_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        int target;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        convert(0, 0, 0, 0, 0, 0);
        convert(503, 6, 7, 8, 0, 0);
        convert(100, 2, 4, 1, 0, 1);
        convert(511, 0, 7, 7, 1, 0);
        convert(255, 3, 7, 3, 0, 5);
        wait_ready("mid_ready_timeout");
        pulse(300);
        repeat (4) cycle();
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", int'(bus.out_valid), 0);
        chk("async_res", int'({bus.r7, bus.r8, bus.r9, bus.range_err}), 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        convert(300, 6, 4, 3, 0, 0);
        target = hs + 512;
        fork
            for (int v = 0; v < 512; v++) begin
                repeat ($urandom_range(0, 2)) cycle();
                wait_ready("sweep_ready_timeout");
                pulse(v);
            end
            begin
                int g = 0;
                while (hs < target && g < 40000) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    cycle();
                    g++;
                end
                bus.out_ready = 1'b0;
            end
        join
        chk("sweep_outputs", hs, target);
        chk("one_out_per_accept", hs, accepts);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/bin_to_rns_9_8_7.md
Name: bin_to_rns_9_8_7

Overview:
- Sequential forward converter: binary integer in, residue triple (mod 7, mod 8, mod 9) out, in the format consumed by the 9-8-7 RNS datapath (compare_9_8_7 operand ordering: x1 = mod 7, x2 = mod 8, x3 = mod 9).
- Bit-serial Horner reduction, MSB first, one bit per clock.
- Valid/ready handshakes on both sides.
- Flags inputs outside the dynamic range 0..503.

Parameters:
- N_BITS, 9, width of the binary input. Must be >= 1. The moduli are fixed at 7/8/9.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  converter can accept a value
- in_data  input  N_BITS  unsigned binary value
- out_valid  output  1  residues valid
- out_ready  input  1  downstream accepts residues
- r7  output  3  in_data mod 7 (0..6)
- r8  output  3  in_data mod 8 (0..7)
- r9  output  4  in_data mod 9 (0..8)
- range_err  output  1  captured value >= 504 (exceeds 7*8*9-1)

Behaviour:
- Reset (rst_n low, async, any state, including mid-conversion):
  - state = IDLE; shift register, bit counter and accumulators cleared.
  - r7, r8, r9, range_err, out_valid = 0.
  - In-flight conversion is discarded, with no output.
  - Operation resumes on the first clk edge after rst_n rises.
- in_ready = (state == IDLE), decoded combinationally from the state register. It reads 1 while in reset, but no capture happens without a clock edge under deasserted reset.
- States IDLE, CONV, DONE:
  - IDLE:
    - On edge with in_valid && in_ready: capture in_data into a shift register.
    - Clear accumulators a7, a8, a9 to 0 and counter to 0.
    - Register range_err_next = (in_data >= 504); this is always 0 when N_BITS <= 8.
    - Go to CONV.
    - Without in_valid, stay in IDLE.
  - CONV:
    - Each edge consumes the MSB b of the shift register, then shifts left by 1.
    - For each m in {7, 8, 9}: t = 2*a_m + b; a_m <= (t >= m) ? t - m : t.
    - Single conditional subtract is sufficient because t <= 2m - 1. Accumulator widths are 3/3/4 bits plus 1 carry bit internally for t.
    - Counter increments. On the edge where counter reaches N_BITS-1 (the last bit):
      - Load r7/r8/r9 from the final t-reduced values.
      - Load range_err.
      - Set out_valid = 1; go to DONE.
  - DONE:
    - out_valid = 1. r7, r8, r9 and range_err are held stable regardless of out_ready.
    - On edge with out_ready: out_valid <= 0, go to IDLE.
    - r7, r8, r9 and range_err keep the last result until the next completion.
- Latency: accept edge E, out_valid high after edge E+N_BITS (9 cycles at default).
- Throughput: at best one conversion per N_BITS+2 cycles. There is no accept in the same cycle as the output handshake.
- in_data is ignored outside IDLE-accept edges. Changing it during CONV has no effect.
- Values >= 504 are still reduced exactly (true residues of the binary value) with range_err = 1. Downstream decides whether to drop them.
- r8 must equal in_data[2:0] (cross-check property); it may be implemented either by Horner or by direct capture.

Test Plan:
- Reset, then in_data=0 with out_ready=1 -> out_valid 9 cycles after accept; (r7, r8, r9) = (0, 0, 0); range_err=0; in_ready returns to 1 the cycle after the output handshake.
- in_data=503 -> (6, 7, 8), range_err=0. in_data=100 -> (2, 4, 1). in_data=511 -> (0, 7, 7), range_err=1.
- Backpressure: convert 255, hold out_ready=0 for 5 cycles -> out_valid stays 1, outputs stay (3, 7, 3), in_ready=0, and a new in_valid pulse with 42 is not captured. Raise out_ready -> one handshake, then IDLE.
- Reset mid-conversion: accept 300, assert rst_n=0 after 4 CONV cycles -> out_valid, residues and range_err = 0 immediately (asynchronous). After release, convert 300 -> (6, 4, 3) with exact 9-cycle latency.
- Exhaustive 0..503 with random out_ready stalls and in_valid gaps:
  - Every result equals (v%7, v%8, v%9).
  - Exactly one output per accepted input, in order.
  - Feeding each pair (v, 503-v) into compare_9_8_7 gives the same gr/eq/le as the integer comparison.
